// File: rtl/hub75_fb_pkg.sv
// Shared HUB75 frame-buffer definitions: drain FSM states, FB address packing, parameter sanity check.
// No logic of its own; latency and backpressure belong to the users.
// Used by the write-in path, the FB readout and the FB arbiter.
package hub75_fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2,
        ST_REL  = 2'd3
    } drain_st_e;

    // FB address layout, MSB to LSB: {row, col, bank, dc_idx}
    function automatic logic [31:0] fb_addr_pack(
        input logic [31:0] row,
        input logic [31:0] col,
        input logic [31:0] bank,
        input logic [31:0] dc,
        input int          lcols,
        input int          lbanks,
        input int          cs
    );
        return (((((row << lcols) | col) << lbanks) | bank) << cs) | dc;
    endfunction

    function automatic bit fb_cfg_ok(
        input int bitdepth,
        input int fb_dw,
        input int fb_dc,
        input int n_lbuf,
        input int fb_aw,
        input int lrows,
        input int lcols,
        input int lbanks
    );
        int cs;
        int lb;
        cs = $clog2(fb_dc);
        lb = $clog2(n_lbuf);
        return (bitdepth <= fb_dw * fb_dc) &&
               ((32'd1 << cs) == fb_dc) &&
               (n_lbuf >= 2) && ((32'd1 << lb) == n_lbuf) &&
               (fb_aw == lrows + lcols + lbanks + cs);
    endfunction

endpackage

// File: rtl/hub75_fb_desc_fifo.sv
// Register FIFO of row descriptors, DEPTH entries, head visible combinationally.
// Push lands on the next edge; level and pointers update together with it.
// Push while full and pop while empty are ignored; caller gates on level.
module hub75_fb_desc_fifo #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 8,
    localparam int LB    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic [LB:0]   level,
    output logic [LB-1:0] wr_ptr,
    output logic [LB-1:0] rd_ptr
);

    logic [DW-1:0] slot_q [DEPTH];
    logic [DW-1:0] slot_d [DEPTH];
    logic [LB-1:0] wr_ptr_q, wr_ptr_d;
    logic [LB-1:0] rd_ptr_q, rd_ptr_d;
    logic [LB:0]   level_q, level_d;
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        push_ok  = push && (level_q != (LB+1)'(DEPTH));
        pop_ok   = pop && (level_q != '0);
        slot_d   = slot_q;
        if (push_ok) begin
            slot_d[wr_ptr_q] = push_dat;
        end
        wr_ptr_d = wr_ptr_q + LB'(push_ok);
        rd_ptr_d = rd_ptr_q + LB'(pop_ok);
        level_d  = level_q + (LB+1)'(push_ok) - (LB+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_dat = slot_q[rd_ptr_q];
    assign level    = level_q;
    assign wr_ptr   = wr_ptr_q;
    assign rd_ptr   = rd_ptr_q;

endmodule

// File: rtl/hub75_linebuffer.sv
// Simple dual-port pixel line storage, one write and one read port on the same clock.
// Read data valid 1 cycle after rd_addr; write takes effect at the clock edge.
// No backpressure; both ports accept every cycle.
module hub75_linebuffer #(
    parameter int N_WORDS    = 1,
    parameter int WORD_WIDTH = 24,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [N_WORDS*WORD_WIDTH-1:0] wr_data,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic [N_WORDS*WORD_WIDTH-1:0] rd_data
);

    logic [N_WORDS*WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [N_WORDS*WORD_WIDTH-1:0] rd_data_d;
    logic [N_WORDS*WORD_WIDTH-1:0] rd_data_q;

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    // Contents are don't-care after reset, so no reset on the array or read register.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/hub75_fb_writein_mq.sv
// Multi-buffered windowed write-in: producer fills line buffers, drain engine copies windows into the FB.
// FB writes trail the column counter by 1 cycle (line buffer read); first write 2 cycles after ctrl_gnt.
// Producer backpressure via wr_row_rdy (free buffer); FB side holds no stalls once granted.
module hub75_fb_writein_mq
    import hub75_fb_pkg::*;
#(
    parameter  int N_BANKS     = 2,
    parameter  int N_ROWS      = 32,
    parameter  int N_COLS      = 64,
    parameter  int BITDEPTH    = 24,
    parameter  int FB_DW       = 16,
    parameter  int FB_DC       = 2,
    parameter  int N_LBUF      = 4,
    parameter  int FB_AW       = 13,
    localparam int LOG_N_BANKS = $clog2(N_BANKS),
    localparam int LOG_N_ROWS  = $clog2(N_ROWS),
    localparam int LOG_N_COLS  = $clog2(N_COLS),
    localparam int CS          = $clog2(FB_DC),
    localparam int LB          = $clog2(N_LBUF)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LOG_N_BANKS-1:0] wr_bank_addr,
    input  logic [LOG_N_ROWS-1:0]  wr_row_addr,
    input  logic [LOG_N_COLS-1:0]  wr_col_lo,
    input  logic [LOG_N_COLS-1:0]  wr_col_hi,
    input  logic                   wr_row_store,
    output logic                   wr_row_rdy,
    input  logic [BITDEPTH-1:0]    wr_data,
    input  logic [LOG_N_COLS-1:0]  wr_col_addr,
    input  logic                   wr_en,
    output logic                   ctrl_req,
    input  logic                   ctrl_gnt,
    output logic                   ctrl_rel,
    output logic [FB_AW-1:0]       fb_addr,
    output logic [FB_DW-1:0]       fb_data,
    output logic                   fb_wren,
    output logic [LB:0]            stat_level,
    output logic                   stat_ovf,
    output logic                   stat_drop
);

    localparam int DCW    = (CS > 0) ? CS : 1;
    localparam int DESC_W = LOG_N_BANKS + LOG_N_ROWS + 2 * LOG_N_COLS;
    localparam logic [DCW-1:0] DC_LAST = DCW'(FB_DC - 1);

    if (!fb_cfg_ok(BITDEPTH, FB_DW, FB_DC, N_LBUF, FB_AW, LOG_N_ROWS, LOG_N_COLS, LOG_N_BANKS)) begin : g_cfg_err
        $error("hub75_fb_writein_mq: inconsistent parameter set");
    end

    drain_st_e               state_q, state_d;
    logic [LOG_N_COLS-1:0]   col_cnt_q, col_cnt_d;
    logic [DCW-1:0]          dc_cnt_q, dc_cnt_d;
    logic                    fb_wren_q, fb_wren_d;
    logic [FB_AW-1:0]        fb_addr_q, fb_addr_d;
    logic [DCW-1:0]          dc_out_q, dc_out_d;
    logic                    stat_ovf_q, stat_ovf_d;
    logic                    stat_drop_q, stat_drop_d;

    logic [DESC_W-1:0]       head_dat;
    logic [LB:0]             level;
    logic [LB-1:0]           wr_ptr;
    logic [LB-1:0]           rd_ptr;
    logic                    rdy;
    logic                    store_ok;
    logic                    pop;
    logic [BITDEPTH-1:0]     lb_rd_data;
    logic [FB_DW*FB_DC-1:0]  pix_ext;

    logic [LOG_N_BANKS-1:0]  head_bank;
    logic [LOG_N_ROWS-1:0]   head_row;
    logic [LOG_N_COLS-1:0]   head_lo;
    logic [LOG_N_COLS-1:0]   head_hi;

    assign head_hi   = head_dat[LOG_N_COLS-1:0];
    assign head_lo   = head_dat[2*LOG_N_COLS-1:LOG_N_COLS];
    assign head_row  = head_dat[2*LOG_N_COLS +: LOG_N_ROWS];
    assign head_bank = head_dat[DESC_W-1 -: LOG_N_BANKS];

    always_comb begin
        rdy         = level < (LB+1)'(N_LBUF);
        store_ok    = wr_row_store && rdy && (wr_col_lo <= wr_col_hi);
        stat_ovf_d  = wr_row_store && !rdy;
        stat_drop_d = wr_row_store && rdy && (wr_col_lo > wr_col_hi);
    end

    hub75_fb_desc_fifo #(
        .DEPTH (N_LBUF),
        .DW    (DESC_W)
    ) u_desc_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (store_ok),
        .push_dat ({wr_bank_addr, wr_row_addr, wr_col_lo, wr_col_hi}),
        .pop      (pop),
        .head_dat (head_dat),
        .level    (level),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr)
    );

    // While full, wr_ptr aliases the buffer being drained, so pixel writes must be blocked.
    hub75_linebuffer #(
        .N_WORDS    (1),
        .WORD_WIDTH (BITDEPTH),
        .ADDR_WIDTH (LB + LOG_N_COLS)
    ) u_linebuf (
        .clk     (clk),
        .wr_addr ({wr_ptr, wr_col_addr}),
        .wr_data (wr_data),
        .wr_en   (wr_en && rdy),
        .rd_addr ({rd_ptr, col_cnt_q}),
        .rd_data (lb_rd_data)
    );

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        dc_cnt_d  = dc_cnt_q;
        fb_wren_d = 1'b0;
        fb_addr_d = '0;
        dc_out_d  = '0;
        pop       = 1'b0;
        ctrl_req  = 1'b0;
        ctrl_rel  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                ctrl_req = 1'b1;
                if (ctrl_gnt) begin
                    state_d   = ST_RUN;
                    col_cnt_d = head_lo;
                    dc_cnt_d  = '0;
                end
            end
            ST_RUN: begin
                fb_wren_d = 1'b1;
                fb_addr_d = FB_AW'(fb_addr_pack(32'(head_row), 32'(col_cnt_q), 32'(head_bank),
                                                32'(dc_cnt_q), LOG_N_COLS, LOG_N_BANKS, CS));
                dc_out_d  = dc_cnt_q;
                if (dc_cnt_q == DC_LAST) begin
                    dc_cnt_d = '0;
                    if (col_cnt_q == head_hi) begin
                        state_d = ST_REL;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end else begin
                    dc_cnt_d = dc_cnt_q + 1'b1;
                end
            end
            ST_REL: begin
                // Last FB word is on the bus now; skipping IDLE keeps back-to-back requests gapless.
                ctrl_rel = 1'b1;
                pop      = 1'b1;
                state_d  = ((level > (LB+1)'(1)) || store_ok) ? ST_REQ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            col_cnt_q   <= '0;
            dc_cnt_q    <= '0;
            fb_wren_q   <= 1'b0;
            fb_addr_q   <= '0;
            dc_out_q    <= '0;
            stat_ovf_q  <= 1'b0;
            stat_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            dc_cnt_q    <= dc_cnt_d;
            fb_wren_q   <= fb_wren_d;
            fb_addr_q   <= fb_addr_d;
            dc_out_q    <= dc_out_d;
            stat_ovf_q  <= stat_ovf_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    // Word select happens after the read register; gating keeps fb_data at 0 between bursts.
    always_comb begin
        pix_ext = (FB_DW*FB_DC)'(lb_rd_data);
        fb_data = fb_wren_q ? pix_ext[dc_out_q*FB_DW +: FB_DW] : '0;
    end

    assign fb_wren    = fb_wren_q;
    assign fb_addr    = fb_addr_q;
    assign wr_row_rdy = rdy;
    assign stat_level = level;
    assign stat_ovf   = stat_ovf_q;
    assign stat_drop  = stat_drop_q;

endmodule
